command_decoder: RTL and testbench



---
 rtl/command_decoder.sv | 106 ++++++++++
 tb/tb_command_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/command_decoder.sv
// rtl/command_decoder.sv - SUMP byte-stream command decoder (short/long commands, inter-byte timeout)
module command_decoder #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clock,
  input  logic        ext_reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  opcode,
  output logic [31:0] command,
  output logic        cmd_recv_rx,
  output logic        cmd_pending,
  output logic        timeout_err
);

  typedef enum logic {IDLE, ARGS} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nx;
  logic [7:0]        op_r, op_nx;
  logic [31:0]       arg_r, arg_nx;
  logic [1:0]        byte_cnt, byte_cnt_nx;
  logic [CNT_W-1:0]  to_cnt, to_cnt_nx;
  logic [7:0]        opcode_nx;
  logic [31:0]       command_nx;
  logic              recv_nx, to_err_nx;

  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state       <= IDLE;
      op_r        <= '0;
      arg_r       <= '0;
      byte_cnt    <= '0;
      to_cnt      <= '0;
      opcode      <= '0;
      command     <= '0;
      cmd_recv_rx <= 1'b0;
      cmd_pending <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      op_r        <= op_nx;
      arg_r       <= arg_nx;
      byte_cnt    <= byte_cnt_nx;
      to_cnt      <= to_cnt_nx;
      opcode      <= opcode_nx;
      command     <= command_nx;
      cmd_recv_rx <= recv_nx;
      cmd_pending <= (state_nx == ARGS);
      timeout_err <= to_err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    op_nx       = op_r;
    arg_nx      = arg_r;
    byte_cnt_nx = byte_cnt;
    to_cnt_nx   = to_cnt;
    opcode_nx   = opcode;
    command_nx  = command;
    recv_nx     = 1'b0;
    to_err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (!rx_data[7]) begin
            opcode_nx  = rx_data;
            command_nx = '0;
            recv_nx    = 1'b1;
          end else begin
            op_nx       = rx_data;
            arg_nx      = '0;
            byte_cnt_nx = '0;
            to_cnt_nx   = '0;
            state_nx    = ARGS;
          end
        end
      end
      ARGS: begin
        // An arriving byte always beats timeout expiry in the same cycle.
        if (rx_valid) begin
          arg_nx[{byte_cnt, 3'b000} +: 8] = rx_data;
          byte_cnt_nx = byte_cnt + 2'd1;
          to_cnt_nx   = '0;
          if (byte_cnt == 2'd3) begin
            opcode_nx  = op_r;
            command_nx = {rx_data, arg_r[23:0]};
            recv_nx    = 1'b1;
            state_nx   = IDLE;
          end
        end else if (to_cnt == TO_LAST) begin
          to_err_nx = 1'b1;
          to_cnt_nx = '0;
          state_nx  = IDLE;
        end else begin
          to_cnt_nx = to_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_command_decoder.sv
// tb/tb_command_decoder.sv - scoreboard bench for command_decoder against a byte-queue reference model
module tb_command_decoder;
  localparam int TO = 16;

  logic        clock = 1'b0;
  logic        ext_reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  opcode;
  logic [31:0] command;
  logic        cmd_recv_rx, cmd_pending, timeout_err;

  command_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .ext_reset_n(ext_reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .opcode(opcode), .command(command), .cmd_recv_rx(cmd_recv_rx),
    .cmd_pending(cmd_pending), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_to;
    logic [7:0]  op;
    logic [31:0] cmd;
    int          cyc;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  part[$];
  bit          pend_exp[int];
  int          silence = 0;
  logic [7:0]  last_op = '0;
  logic [31:0] last_cmd = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: collect bytes of a command; expect completion or timeout next cycle.
  task automatic model(input bit v, input logic [7:0] b);
    int c;
    ev_t e;
    c = cyc + 1;
    if (v) begin
      silence = 0;
      if (part.size() == 0 && b < 8'h80) begin
        last_op = b; last_cmd = 0;
        e = '{0, last_op, last_cmd, c}; exp_q.push_back(e);
      end else begin
        part.push_back(b);
        if (part.size() == 5) begin
          last_op  = part[0];
          last_cmd = {part[4], part[3], part[2], part[1]};
          e = '{0, last_op, last_cmd, c}; exp_q.push_back(e);
          part.delete();
        end
      end
    end else if (part.size() > 0) begin
      silence++;
      if (silence == TO) begin
        e = '{1, last_op, last_cmd, c}; exp_q.push_back(e);
        part.delete();
        silence = 0;
      end
    end
    pend_exp[c] = (part.size() > 0);
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    @(posedge clock);
    #1;
    rx_valid = v;
    rx_data  = v ? b : 8'h00;
    model(v, b);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    step(1'b1, b);
    for (int i = 0; i < gap; i++) step(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_opcode"}, 64'(opcode), 64'h0);
    chk({tag, "_command"}, 64'(command), 64'h0);
    chk({tag, "_recv"}, 64'(cmd_recv_rx), 64'h0);
    chk({tag, "_pending"}, 64'(cmd_pending), 64'h0);
    chk({tag, "_timeout"}, 64'(timeout_err), 64'h0);
  endtask

  // Monitor: pops an expected event whenever the DUT pulses, flags missed or extra pulses.
  always @(negedge clock) begin
    if (ext_reset_n) begin
      if (cmd_recv_rx && timeout_err) chk("pulse_overlap", 64'h1, 64'h0);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk(exp_q[0].is_to ? "missed_timeout" : "missed_cmd", 64'(exp_q[0].cyc), 64'(cyc));
        void'(exp_q.pop_front());
      end
      if (cmd_recv_rx || timeout_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {cmd_recv_rx, timeout_err}, 64'h0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
          chk("pulse_kind", {cmd_recv_rx, timeout_err}, e.is_to ? 64'h1 : 64'h2);
          chk("opcode", 64'(opcode), 64'(e.op));
          chk("command", 64'(command), 64'(e.cmd));
        end
      end
      chk("cmd_pending", 64'(cmd_pending), pend_exp.exists(cyc) ? 64'(pend_exp[cyc]) : 64'h0);
    end
  end

  initial begin
    #2;
    check_reset_outputs("reset");
    #20;
    ext_reset_n = 1'b1;

    // Short command
    send(8'h02, 3);
    // Long command spaced 10 cycles
    send(8'hC0, 10); send(8'h78, 10); send(8'h56, 10); send(8'h34, 10); send(8'h12, 3);
    // Timeout, then short command
    send(8'h81, 0); send(8'hAA, 20);
    send(8'h01, 2);
    // Race: byte lands exactly in the expiry cycle
    send(8'h85, TO - 1); send(8'h11, TO - 1); send(8'h22, TO - 1); send(8'h33, TO - 1); send(8'h44, 2);
    // SUMP reset then back-to-back long command
    for (int i = 0; i < 5; i++) send(8'h00, 0);
    send(8'h80, 0); send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    send(8'h03, 3);

    // Async reset mid-command
    send(8'h81, 0); send(8'h55, 0); send(8'h66, 0);
    #3;
    ext_reset_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    check_reset_outputs("midreset");
    part.delete(); silence = 0; last_op = '0; last_cmd = '0; pend_exp.delete();
    chk("no_pending_events_at_reset", 64'(exp_q.size()), 64'h0);
    exp_q.delete();
    #12;
    ext_reset_n = 1'b1;
    send(8'hC1, 0); send(8'h01, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 3);

    // Random traffic with gaps that sometimes expire the timeout
    for (int n = 0; n < 400; n++) begin
      logic [7:0] b;
      int g;
      b = 8'($urandom);
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 2, TO + 2) : $urandom_range(0, 3);
      send(b, g);
    end
    idle(TO + 4);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
